// File: rtl/mem_access_stage.sv
// Data-memory access stage of the RV32I pipeline.
// Registers an execute-stage packet, issues a word-aligned load/store to the
// data memory port, aligns and extends load data, and presents a writeback
// packet downstream. Both sides use a valid/ready handshake.
// Optional build macro: MEM_MISALIGN_TRAP_EN adds misalign_err and turns
// misaligned halfword/word accesses into traps instead of forcing alignment.
module mem_access_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_read,
  input  logic              in_write,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [4:0]        in_rd,
  input  logic              in_load_regfile,
  input  logic [DATA_W-1:0] in_result,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_byte_enable,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_resp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_rd,
  output logic              out_load_regfile,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic [DATA_W-1:0] out_data,
  output logic              misalign_err
`else
  output logic [DATA_W-1:0] out_data
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t state, state_nxt;

  logic              accept, go_req, trap;
  logic              r_read, r_write, r_load_regfile;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_data;
  logic [4:0]        r_rd;
  logic [1:0]        r_size, r_off;
  logic [DATA_W-1:0] load_shift, load_val, st_wdata;
  logic [3:0]        st_mask;

  // Access size; loads take precedence when both read and write are set.
  function automatic logic [1:0] access_size(input logic is_load, input logic [2:0] f3);
    if (is_load) begin
      unique case (f3)
        3'b000, 3'b100: return SZ_BYTE;
        3'b001, 3'b101: return SZ_HALF;
        default:        return SZ_WORD;
      endcase
    end else begin
      unique case (f3)
        3'b000:  return SZ_BYTE;
        3'b001:  return SZ_HALF;
        default: return SZ_WORD;
      endcase
    end
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  logic [1:0] in_size;
  logic       r_misalign;
  // Detect misaligned halfword/word memory ops at acceptance time.
  always_comb begin
    in_size = access_size(in_read, in_funct3);
    trap    = (in_read | in_write) &&
              (((in_size == SZ_HALF) && in_addr[0]) ||
               ((in_size == SZ_WORD) && (in_addr[1:0] != 2'b00)));
  end
  assign misalign_err = r_misalign && (state == HOLD);
`else
  assign trap = 1'b0;
`endif

  assign go_req = (in_read | in_write) && !trap;
  assign accept = in_valid && in_ready;

  // Next state and upstream ready.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = go_req ? REQ : HOLD;
      end
      REQ: begin
        if (dmem_resp) state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) state_nxt = go_req ? REQ : HOLD;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Offset, load alignment/extension and store replication from the registered packet.
  always_comb begin
    r_size = access_size(r_read, r_funct3);
    unique case (r_size)
      SZ_BYTE: r_off = r_addr[1:0];
      SZ_HALF: r_off = {r_addr[1], 1'b0};
      default: r_off = 2'b00;
    endcase
    load_shift = dmem_rdata >> {r_off, 3'b000};
    unique case (r_size)
      SZ_BYTE: load_val = r_funct3[2] ? {24'd0, load_shift[7:0]}
                                      : {{24{load_shift[7]}}, load_shift[7:0]};
      SZ_HALF: load_val = r_funct3[2] ? {16'd0, load_shift[15:0]}
                                      : {{16{load_shift[15]}}, load_shift[15:0]};
      default: load_val = load_shift;
    endcase
    unique case (r_size)
      SZ_BYTE: begin st_wdata = {4{r_wdata[7:0]}};  st_mask = 4'b0001 << r_off; end
      SZ_HALF: begin st_wdata = {2{r_wdata[15:0]}}; st_mask = 4'b0011 << r_off; end
      default: begin st_wdata = r_wdata;            st_mask = 4'b1111;          end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Packet registers: loaded on acceptance, load data captured on response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read         <= 1'b0;
      r_write        <= 1'b0;
      r_funct3       <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_rd           <= '0;
      r_load_regfile <= 1'b0;
      r_data         <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      r_misalign     <= 1'b0;
`endif
    end else if (accept) begin
      r_read         <= in_read;
      r_write        <= in_write;
      r_funct3       <= in_funct3;
      r_addr         <= in_addr;
      r_wdata        <= in_wdata;
      r_rd           <= in_rd;
      r_load_regfile <= in_load_regfile && !trap;
      r_data         <= trap ? DATA_W'(in_addr) : ((in_read | in_write) ? '0 : in_result);
`ifdef MEM_MISALIGN_TRAP_EN
      r_misalign     <= trap;
`endif
    end else if (state == REQ && dmem_resp) begin
      r_data <= r_read ? load_val : '0;
    end
  end

  assign dmem_read        = (state == REQ) && r_read;
  assign dmem_write       = (state == REQ) && r_write && !r_read;
  assign dmem_address     = (state == REQ) ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_wdata       = dmem_write ? st_wdata : '0;
  assign dmem_byte_enable = dmem_write ? st_mask : '0;

  assign out_valid        = (state == HOLD);
  assign out_rd           = r_rd;
  assign out_load_regfile = r_load_regfile;
  assign out_data         = r_data;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_read, in_write;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata, in_result;
  logic [4:0]  in_rd;
  logic        in_load_regfile;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_byte_enable;
  logic        dmem_resp;
  logic        out_valid, out_ready, out_load_regfile;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_read(in_read), .in_write(in_write), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .in_load_regfile(in_load_regfile), .in_result(in_result),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_load_regfile(out_load_regfile),
`ifdef MEM_MISALIGN_TRAP_EN
    .out_data(out_data),
    .misalign_err(misalign_err)
`else
    .out_data(out_data)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_pkt(input logic rd_, input logic wr_, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic lr, input logic [31:0] res);
    in_valid = 1'b1; in_read = rd_; in_write = wr_; in_funct3 = f3;
    in_addr = addr; in_wdata = wdata; in_rd = rd; in_load_regfile = lr; in_result = res;
  endtask

  // Load with response in the first REQ cycle; wr_ sets the write bit too.
  task automatic run_load(input string tag, input logic wr_, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [31:0] exp_data);
    @(negedge clk);
    set_pkt(1'b1, wr_, f3, addr, 32'hCAFE_F00D, 5'd5, 1'b1, 32'hAAAA_AAAA);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_rd"},   {31'd0, dmem_read}, 32'd1);
    check({tag, "_wr"},   {31'd0, dmem_write}, 32'd0);
    check({tag, "_addr"}, dmem_address, exp_addr);
    check({tag, "_be"},   {28'd0, dmem_byte_enable}, 32'd0);
    dmem_rdata = rdata; dmem_resp = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    check({tag, "_ov"},   {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_ord"},  {27'd0, out_rd}, 32'd5);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_addr,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                           input int unsigned stall);
    @(negedge clk);
    set_pkt(1'b0, 1'b1, f3, addr, wdata, 5'd0, 1'b0, 32'h1111_1111);
    out_ready = 1'b0;
    @(negedge clk);
    for (int unsigned i = 0; i <= stall; i++) begin
      check({tag, "_wr"},    {31'd0, dmem_write}, 32'd1);
      check({tag, "_rd"},    {31'd0, dmem_read}, 32'd0);
      check({tag, "_addr"},  dmem_address, exp_addr);
      check({tag, "_wdata"}, dmem_wdata, exp_wdata);
      check({tag, "_be"},    {28'd0, dmem_byte_enable}, {28'd0, exp_be});
      check({tag, "_irdy"},  {31'd0, in_ready}, 32'd0);
      if (i < stall) @(negedge clk);
    end
    in_valid = 1'b0; dmem_resp = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    check({tag, "_ov"},   {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, out_data, 32'd0);
    check({tag, "_lr"},   {31'd0, out_load_regfile}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; dmem_resp = 1'b0; dmem_rdata = '0;
    set_pkt(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd3, 1'b1, 32'h11);
    repeat (3) @(negedge clk);
    check("rst_irdy", {31'd0, in_ready}, 32'd1);
    check("rst_ov",   {31'd0, out_valid}, 32'd0);
    check("rst_dr",   {31'd0, dmem_read}, 32'd0);
    check("rst_dw",   {31'd0, dmem_write}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_lr",   {31'd0, out_load_regfile}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_ov",   {31'd0, out_valid}, 32'd1);
    check("first_data", out_data, 32'h11);
    check("first_rd",   {27'd0, out_rd}, 32'd3);
    check("first_irdy", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("first_idle", {31'd0, out_valid}, 32'd0);

    run_load("lb",   1'b0, 3'b000, 32'h1003, 32'h80FF_1234, 32'h1000, 32'hFFFF_FF80);
    run_load("lbu",  1'b0, 3'b100, 32'h1003, 32'h80FF_1234, 32'h1000, 32'h0000_0080);
    run_load("lb0",  1'b0, 3'b000, 32'h1000, 32'h80FF_1234, 32'h1000, 32'h0000_0034);
    run_load("lh",   1'b0, 3'b001, 32'h1002, 32'h80FF_1234, 32'h1000, 32'hFFFF_80FF);
    run_load("lhu",  1'b0, 3'b101, 32'h1003, 32'h80FF_1234, 32'h1000, 32'h0000_80FF);
    run_load("lh1",  1'b0, 3'b001, 32'h1001, 32'h0000_9234, 32'h1000, 32'hFFFF_9234);
    run_load("lu3",  1'b0, 3'b011, 32'h1000, 32'h80FF_1234, 32'h1000, 32'h80FF_1234);
    run_load("rdwr", 1'b1, 3'b010, 32'h5004, 32'h0BAD_F00D, 32'h5004, 32'h0BAD_F00D);

    run_store("sh", 3'b001, 32'h2002, 32'hDEAD_BEEF, 32'h2000, 32'hBEEF_BEEF, 4'b1100, 3);
    run_store("sb", 3'b000, 32'h2001, 32'h1234_56A5, 32'h2000, 32'hA5A5_A5A5, 4'b0010, 0);
    run_store("sw", 3'b010, 32'h2007, 32'h0102_0304, 32'h2004, 32'h0102_0304, 4'b1111, 0);

    // Back-to-back: two pass-through ops then a load, downstream always ready.
    @(negedge clk);
    out_ready = 1'b1;
    set_pkt(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd7, 1'b1, 32'h55);
    @(negedge clk);
    check("b2b_ov1",  {31'd0, out_valid}, 32'd1);
    check("b2b_d1",   out_data, 32'h55);
    check("b2b_rd1",  {27'd0, out_rd}, 32'd7);
    check("b2b_irdy", {31'd0, in_ready}, 32'd1);
    set_pkt(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd8, 1'b1, 32'h66);
    @(negedge clk);
    check("b2b_ov2", {31'd0, out_valid}, 32'd1);
    check("b2b_d2",  out_data, 32'h66);
    check("b2b_rd2", {27'd0, out_rd}, 32'd8);
    set_pkt(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 5'd9, 1'b1, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_req", {31'd0, dmem_read}, 32'd1);
    check("b2b_ov3", {31'd0, out_valid}, 32'd0);
    dmem_rdata = 32'h1234_5678; dmem_resp = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    check("b2b_ov4", {31'd0, out_valid}, 32'd1);
    check("b2b_d4",  out_data, 32'h1234_5678);
    check("b2b_rd4", {27'd0, out_rd}, 32'd9);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_idle", {31'd0, out_valid}, 32'd0);

    // Reset with a request outstanding; a late response must be ignored.
    @(negedge clk);
    set_pkt(1'b1, 1'b0, 3'b010, 32'h6000, 32'h0, 5'd4, 1'b1, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    check("rstq_req", {31'd0, dmem_read}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstq_dr",   {31'd0, dmem_read}, 32'd0);
    check("rstq_addr", dmem_address, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; dmem_rdata = 32'hFFFF_FFFF; dmem_resp = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    check("rstq_ov",   {31'd0, out_valid}, 32'd0);
    check("rstq_irdy", {31'd0, in_ready}, 32'd1);
    check("rstq_dr2",  {31'd0, dmem_read}, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    set_pkt(1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 5'd6, 1'b1, 32'h0);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("mis_dr",   {31'd0, dmem_read}, 32'd0);
    check("mis_ov",   {31'd0, out_valid}, 32'd1);
    check("mis_err",  {31'd0, misalign_err}, 32'd1);
    check("mis_data", out_data, 32'h3001);
    check("mis_lr",   {31'd0, out_load_regfile}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("mis_clr",  {31'd0, misalign_err}, 32'd0);
    run_load("lw_al", 1'b0, 3'b010, 32'h3000, 32'h80FF_1234, 32'h3000, 32'h80FF_1234);
`else
    run_load("lw_mis", 1'b0, 3'b010, 32'h3001, 32'h80FF_1234, 32'h3000, 32'h80FF_1234);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
